// File: rtl/frame_address_pool.sv
// frame_address_pool: circular free list of frame addresses, AXI4-Stream in/out.
// Optional FRAME_POOL_DUP_CHECK_EN adds a residency bitmap and the err_dup flag.
module frame_address_pool #(
  parameter int ADDR_BITS = 9,
  parameter int LOW_WATER = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [15:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [15:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [ADDR_BITS:0]   free_count,
  output logic                 low_water,
  output logic                 err_range,
  output logic                 err_overflow
`ifdef FRAME_POOL_DUP_CHECK_EN
  ,
  output logic                 err_dup
`endif
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] ONE = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS:0] LW = (ADDR_BITS + 1)'(LOW_WATER);

  logic [ADDR_BITS-1:0] r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_rdata;
  logic [ADDR_BITS:0]   r_wptr;
  logic [ADDR_BITS:0]   r_rptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 r_tready;
  logic                 r_pend;
  logic                 r_tvalid;
  logic [15:0]          r_tdata;
  logic                 r_err_range;
  logic                 r_err_ovf;

  logic                 w_accept;
  logic                 w_in_range;
  logic [ADDR_BITS-1:0] w_addr;
  logic                 w_dup;
  logic                 w_store;
  logic                 w_grant;
  logic                 w_ram_ne;
  logic                 w_out_free;
  logic                 w_fire;
  logic [ADDR_BITS:0]   w_count_nxt;

  assign w_accept   = s_axis_tvalid & r_tready;
  assign w_in_range = ~|s_axis_tdata[15:ADDR_BITS];
  assign w_addr     = s_axis_tdata[ADDR_BITS-1:0];
  assign w_store    = w_accept & w_in_range & ~w_dup;
  assign w_grant    = r_tvalid & m_axis_tready;
  assign w_ram_ne   = (r_wptr != r_rptr);
  assign w_out_free = ~r_tvalid | m_axis_tready;
  assign w_fire     = w_ram_ne & w_out_free;

  always_comb begin
    w_count_nxt = r_count;
    if (w_store & ~w_grant)
      w_count_nxt = r_count + ONE;
    else if (~w_store & w_grant)
      w_count_nxt = r_count - ONE;
  end

  // RAM has no reset; the read is registered into r_rdata.
  always_ff @(posedge aclk) begin
    if (w_store)
      r_mem[r_wptr[ADDR_BITS-1:0]] <= w_addr;
    if (w_fire)
      r_rdata <= r_mem[r_rptr[ADDR_BITS-1:0]];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_tready    <= 1'b0;
      r_pend      <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_err_range <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_tready <= (w_count_nxt != FULL);
      if (w_store)
        r_wptr <= r_wptr + ONE;
      if (w_fire)
        r_rptr <= r_rptr + ONE;
      // r_pend holds the read in flight until the output slot frees up.
      if (w_fire)
        r_pend <= 1'b1;
      else if (w_out_free)
        r_pend <= 1'b0;
      if (w_out_free) begin
        r_tvalid <= r_pend;
        if (r_pend)
          r_tdata <= {{(16 - ADDR_BITS){1'b0}}, r_rdata};
      end
      if (w_accept & ~w_in_range)
        r_err_range <= 1'b1;
      if (s_axis_tvalid & (r_count == FULL))
        r_err_ovf <= 1'b1;
    end
  end

`ifdef FRAME_POOL_DUP_CHECK_EN
  logic [DEPTH-1:0] r_resident;
  logic             r_err_dup;

  assign w_dup   = w_accept & w_in_range & r_resident[w_addr];
  assign err_dup = r_err_dup;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_resident <= '0;
      r_err_dup  <= 1'b0;
    end else begin
      if (w_grant)
        r_resident[r_tdata[ADDR_BITS-1:0]] <= 1'b0;
      if (w_store)
        r_resident[w_addr] <= 1'b1;
      if (w_dup)
        r_err_dup <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign s_axis_tready = r_tready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign free_count    = r_count;
  assign low_water     = (r_count < LW);
  assign err_range     = r_err_range;
  assign err_overflow  = r_err_ovf;

endmodule

// File: tb/tb_frame_address_pool.sv
// tb_frame_address_pool: directed + random stimulus against a queue model
// of the free list; define FRAME_POOL_DUP_CHECK_EN to cover err_dup.
module tb_frame_address_pool;

  localparam int AW = 9;
  localparam int DEPTH = 512;
  localparam int LW = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [AW:0] free_count;
  logic        low_water;
  logic        err_range;
  logic        err_overflow;
`ifdef FRAME_POOL_DUP_CHECK_EN
  logic        err_dup;
`endif

  frame_address_pool #(.ADDR_BITS(AW), .LOW_WATER(LW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .free_count    (free_count),
    .low_water     (low_water),
    .err_range     (err_range),
    .err_overflow  (err_overflow)
`ifdef FRAME_POOL_DUP_CHECK_EN
    ,
    .err_dup       (err_dup)
`endif
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the pool as an ordered list of held addresses.
  int q[$];
  bit exp_rdy = 1'b0;
  bit e_rng = 1'b0;
  bit e_ovf = 1'b0;
  bit e_dup = 1'b0;
  int idle = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit inr;
    bit res;
    bit grant;
    int a;
    grant = m_tvalid & m_tready;
    if (s_tvalid && q.size() == DEPTH) e_ovf = 1'b1;
    acc = s_tvalid & exp_rdy;
    inr = (int'(s_tdata) < DEPTH);
    a = int'(s_tdata) % DEPTH;
    res = 1'b0;
`ifdef FRAME_POOL_DUP_CHECK_EN
    foreach (q[i]) if (q[i] == a) res = 1'b1;
    if (acc && inr && res) e_dup = 1'b1;
`endif
    if (acc && !inr) e_rng = 1'b1;
    if (grant && q.size() > 0) void'(q.pop_front());
    if (acc && inr && !res) q.push_back(a);
    exp_rdy = (q.size() != DEPTH);
  endtask

  task automatic check_all();
    check("free_count", free_count, q.size());
    check("s_tready", s_tready, exp_rdy);
    check("low_water", low_water, q.size() < LW);
    check("err_range", err_range, e_rng);
    check("err_overflow", err_overflow, e_ovf);
`ifdef FRAME_POOL_DUP_CHECK_EN
    check("err_dup", err_dup, e_dup);
`endif
    check("valid_when_empty", m_tvalid & (q.size() == 0), 0);
    if (m_tvalid && q.size() > 0) check("m_tdata", m_tdata, q[0]);
    if (q.size() > 0 && !m_tvalid) idle++;
    else idle = 0;
    check("egress_latency_ok", idle <= 2, 1);
  endtask

  task automatic cycle(input bit v, input logic [15:0] d, input bit r);
    s_tvalid = v;
    s_tdata = d;
    m_tready = r;
    model_edge();
    @(negedge aclk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_count", free_count, 0);
    check("rst_tready", s_tready, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_low_water", low_water, 1);
    check("rst_err_range", err_range, 0);
    check("rst_err_ovf", err_overflow, 0);
`ifdef FRAME_POOL_DUP_CHECK_EN
    check("rst_err_dup", err_dup, 0);
`endif
    q.delete();
    exp_rdy = 1'b0;
    e_rng = 1'b0;
    e_ovf = 1'b0;
    e_dup = 1'b0;
    idle = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    check_all();
    cycle(0, 16'h0, 0);
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) cycle(1, 16'(i), 0);
  endtask

  initial begin
    int pv;
    int pr;
    bit v;
    logic [15:0] d;

    do_reset();

    fill_all();
    check("fill_count", free_count, DEPTH);
    check("fill_tready", s_tready, 0);
    check("fill_head", m_tdata, 0);

    repeat (3) cycle(1, 16'h0007, 0);
    check("overflow_flag", err_overflow, 1);
    check("overflow_count", free_count, DEPTH);

    for (int i = 0; i < DEPTH; i++) begin
      check("drain_valid", m_tvalid, 1);
      cycle(0, 16'h0, 1);
    end
    check("drain_count", free_count, 0);
    check("drain_empty", m_tvalid, 0);

    cycle(1, 16'h0123, 0);
    check("lat_n", m_tvalid, 0);
    cycle(0, 16'h0, 0);
    check("lat_n1", m_tvalid, 0);
    cycle(0, 16'h0, 0);
    check("lat_n2", m_tvalid, 1);
    check("lat_data", m_tdata, 16'h0123);
    cycle(0, 16'h0, 1);

    fill_all();
    for (int i = 0; i < 300; i++) cycle(0, 16'h0, 1);
    for (int i = 0; i < 300; i++) cycle(1, 16'(i), 0);
    check("wrap_full", free_count, DEPTH);
    for (int i = 0; i < 600 && q.size() > 0; i++) cycle(0, 16'h0, 1);
    check("wrap_drained", free_count, 0);

    cycle(1, 16'h0200, 0);
    check("range_flag", err_range, 1);
    check("range_count", free_count, 0);

`ifdef FRAME_POOL_DUP_CHECK_EN
    cycle(1, 16'h0005, 0);
    cycle(1, 16'h0005, 0);
    check("dup_flag", err_dup, 1);
    check("dup_count", free_count, 1);
    repeat (3) cycle(0, 16'h0, 1);
`endif

    for (int e = 0; e < 8; e++) begin
      pv = $urandom_range(0, 100);
      pr = $urandom_range(0, 100);
      for (int c = 0; c < 500; c++) begin
        v = ($urandom_range(0, 99) < pv);
        if ($urandom_range(0, 15) == 0)
          d = 16'($urandom_range(512, 65535));
        else
          d = 16'($urandom_range(0, 511));
        cycle(v, d, $urandom_range(0, 99) < pr);
      end
    end

    for (int i = 0; i < 40; i++) cycle(1, 16'(i), i[0]);
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 16'(i), 0);
    check("refill_count", free_count, 20);
    check("refill_head", m_tdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
